// File: rtl/vram_arbiter_if.sv
// Video RAM arbiter bus: timing position, display fetch, client requests, RAM port.
// Slave modport is the arbiter's view; master modport is the surrounding system.
// Grouping only; carries no state of its own.
interface vram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 16,
    parameter int DW   = 8
);
    logic [9:0]         sx;
    logic [9:0]         sy;
    logic [AW-1:0]      disp_addr;
    logic [DW-1:0]      disp_rdata;
    logic               disp_rvalid;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;
    logic               frame_start;

    modport slave (
        input  sx, sy, disp_addr, req, req_we, req_addr, req_wdata, mem_rdata,
        output disp_rdata, disp_rvalid, gnt, rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, frame_start
    );

    modport master (
        output sx, sy, disp_addr, req, req_we, req_addr, req_wdata, mem_rdata,
        input  disp_rdata, disp_rvalid, gnt, rvalid, rdata,
               mem_en, mem_we, mem_addr, mem_wdata, frame_start
    );
endinterface

// File: rtl/vram_arbiter.sv
// Shares a single-port video RAM between the display fetch and round-robin game clients.
// Latency: grant is combinational (0 cycles), read data returns 1 cycle after the access.
// Backpressure: display window always wins; clients hold req until their gnt pulse.
module vram_arbiter #(
    parameter int              NREQ        = 4,
    parameter int              AW          = 16,
    parameter int              DW          = 8,
    parameter logic [NREQ-1:0] VBLANK_ONLY = '0,
    parameter int              HA_END      = 639,
    parameter int              LINE        = 799,
    parameter int              VA_END      = 479,
    parameter int              SCREEN      = 524
) (
    input  logic          clk_pix,
    input  logic          rst_pix_n,
    vram_arbiter_if.slave bus
);
    localparam int         PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [9:0] HA_PRE  = 10'(HA_END - 1);
    localparam logic [9:0] LINE_L  = 10'(LINE);
    localparam logic [9:0] VA_L    = 10'(VA_END);
    localparam logic [9:0] SCR_L   = 10'(SCREEN);
    localparam logic [9:0] VBS_L   = 10'(VA_END + 1);

    // Add an offset to a client index, wrapping modulo NREQ.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int inc);
        int s;
        s = int'(base) + inc;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    logic            win;
    logic            vbl;
    logic [NREQ-1:0] elig;
    logic            found;
    logic [PW-1:0]   sel;

    logic [NREQ-1:0] gnt;
    logic            mem_en;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;

    logic [PW-1:0]   ptr_q,         ptr_d;
    logic            own_disp_q,    own_disp_d;
    logic [NREQ-1:0] own_cli_q,     own_cli_d;
    logic            frame_start_q, frame_start_d;

    // Display window covers each active pixel's fetch one cycle ahead, including
    // the first pixel of the next active line (fetched at sx==LINE).
    always_comb begin
        win  = ((bus.sy <= VA_L) && (bus.sx <= HA_PRE)) ||
               ((bus.sx == LINE_L) && ((bus.sy < VA_L) || (bus.sy == SCR_L)));
        vbl  = (bus.sy > VA_L);
        elig = bus.req & ~(VBLANK_ONLY & {NREQ{~vbl}});
    end

    // Pick the first eligible client at or after the pointer; scanning from the far
    // end lets the nearest hit overwrite the others.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[wrap_add(ptr_q, k)]) begin
                found = 1'b1;
                sel   = wrap_add(ptr_q, k);
            end
        end
    end

    // Drive the RAM port: display in the window, granted client otherwise; all
    // strobes and buses are quiet during reset and idle cycles.
    always_comb begin
        gnt       = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (rst_pix_n) begin
            if (win) begin
                mem_en   = 1'b1;
                mem_addr = bus.disp_addr;
            end else if (found) begin
                gnt[sel]  = 1'b1;
                mem_en    = 1'b1;
                mem_we    = bus.req_we[sel];
                mem_addr  = bus.req_addr[int'(sel)*AW +: AW];
                mem_wdata = bus.req_wdata[int'(sel)*DW +: DW];
            end
        end
    end

    // Next-state: pointer moves past the winner, owner tag records who issued a read.
    always_comb begin
        ptr_d         = (gnt != '0) ? wrap_add(sel, 1) : ptr_q;
        own_disp_d    = win;
        own_cli_d     = gnt & ~bus.req_we;
        frame_start_d = (bus.sx == 10'd0) && (bus.sy == VBS_L);
    end

    // Registered arbitration state with synchronous active-low reset.
    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            ptr_q         <= '0;
            own_disp_q    <= 1'b0;
            own_cli_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            own_disp_q    <= own_disp_d;
            own_cli_q     <= own_cli_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.gnt         = gnt;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.disp_rvalid = own_disp_q;
    assign bus.rvalid      = own_cli_q;
    assign bus.disp_rdata  = bus.mem_rdata;
    assign bus.rdata       = bus.mem_rdata;
    assign bus.frame_start = frame_start_q;
endmodule
